out_tile_serializer: RTL and testbench

OUT_TILE_SERIALIZER -- requirements
Module: out_tile_serializer

---
 rtl/out_tile_serializer.sv | 190 +++++++++++++++++++
 tb/tb_out_tile_serializer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/out_tile_serializer.sv
// Ping-pong buffer that turns m x m pixel tiles into a raster-order pixel stream, m rows per bank.
// Build option: define OTS_ROW_LAST_EN to add the o_row_last end-of-row marker.
module out_tile_serializer #(
    parameter int OW = 512,
    parameter int m  = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [m*m*8-1:0] i_tile,
    input  logic             i_tile_valid,
    output logic             o_tile_ready,
    output logic [7:0]       o_data,
    output logic             o_data_valid,
    input  logic             i_data_ready
`ifdef OTS_ROW_LAST_EN
    ,
    output logic             o_row_last
`endif
);

    localparam int TW  = OW / m;
    localparam int TCW = (TW > 1) ? $clog2(TW) : 1;
    localparam int CW  = (OW > 1) ? $clog2(OW) : 1;
    localparam int RW  = (m > 1) ? $clog2(m) : 1;
    localparam int AW  = $clog2(2 * TW);

    typedef enum logic {IDLE, DRAIN} state_t;
    state_t state_q, state_d;

    logic           wr_bank_q, wr_bank_d;
    logic [TCW-1:0] tcol_q, tcol_d;
    logic [1:0]     full_q, full_d;
    logic           rd_bank_q, rd_bank_d;
    logic [RW-1:0]  row_q, row_d;
    logic [CW-1:0]  col_q, col_d;
    logic [7:0]     data_q, data_d;
    logic           valid_q, valid_d;
`ifdef OTS_ROW_LAST_EN
    logic           row_last_q, row_last_d;
`endif

    logic           tile_acc, tile_last, pix_last, xfer, bank_done, load;
    logic [AW-1:0]  wr_addr, rd_addr;
    logic [m*8-1:0] rd_word [m];
    logic [m*8-1:0] sel_word;
    int             ld_tc, ld_sub;

    assign o_tile_ready = !full_q[wr_bank_q];
    assign tile_acc     = i_tile_valid && o_tile_ready;
    assign tile_last    = (tcol_q == TCW'(TW - 1));
    assign pix_last     = (row_q == RW'(m - 1)) && (col_q == CW'(OW - 1));
    assign xfer         = valid_q && i_data_ready;
    assign wr_addr      = AW'(int'(wr_bank_q) * TW + int'(tcol_q));

    // One memory per tile row; each word holds the m pixels a tile contributes to that row.
    generate
        for (genvar gi = 0; gi < m; gi++) begin : g_row
            logic [m*8-1:0] mem [2*TW];
            always_ff @(posedge i_clk) begin
                if (tile_acc) begin
                    mem[wr_addr] <= i_tile[(m-1-gi)*m*8 +: m*8];
                end
            end
            assign rd_word[gi] = mem[rd_addr];
        end
    endgenerate

    always_comb begin
        wr_bank_d = wr_bank_q;
        tcol_d    = tcol_q;
        full_d    = full_q;
        if (tile_acc) begin
            if (tile_last) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = !wr_bank_q;
                tcol_d            = '0;
            end else begin
                tcol_d = tcol_q + TCW'(1);
            end
        end
        if (bank_done) begin
            full_d[rd_bank_q] = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (full_q[rd_bank_q]) state_d = DRAIN;
            DRAIN:   if (xfer && pix_last && !full_q[!rd_bank_q]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The *_d pointer always names the pixel loaded into the output register when load is set.
    always_comb begin
        rd_bank_d = rd_bank_q;
        row_d     = row_q;
        col_d     = col_q;
        valid_d   = valid_q;
        bank_done = 1'b0;
        load      = 1'b0;
        case (state_q)
            IDLE: begin
                if (full_q[rd_bank_q]) begin
                    load  = 1'b1;
                    row_d = '0;
                    col_d = '0;
                end
            end
            DRAIN: begin
                if (xfer) begin
                    if (pix_last) begin
                        bank_done = 1'b1;
                        rd_bank_d = !rd_bank_q;
                        row_d     = '0;
                        col_d     = '0;
                        load      = full_q[!rd_bank_q];
                        valid_d   = full_q[!rd_bank_q];
                    end else if (col_q == CW'(OW - 1)) begin
                        row_d = row_q + RW'(1);
                        col_d = '0;
                        load  = 1'b1;
                    end else begin
                        col_d = col_q + CW'(1);
                        load  = 1'b1;
                    end
                end
            end
            default: ;
        endcase
        if (load) begin
            valid_d = 1'b1;
        end
    end

    always_comb begin
        ld_tc    = int'(col_d) / m;
        ld_sub   = int'(col_d) % m;
        rd_addr  = AW'(int'(rd_bank_d) * TW + ld_tc);
        sel_word = rd_word[row_d];
        data_d   = load ? sel_word[(m-1-ld_sub)*8 +: 8] : data_q;
`ifdef OTS_ROW_LAST_EN
        row_last_d = load ? (col_d == CW'(OW - 1)) : row_last_q;
`endif
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_bank_q  <= 1'b0;
            tcol_q     <= '0;
            full_q     <= 2'b00;
            rd_bank_q  <= 1'b0;
            row_q      <= '0;
            col_q      <= '0;
            data_q     <= 8'h00;
            valid_q    <= 1'b0;
`ifdef OTS_ROW_LAST_EN
            row_last_q <= 1'b0;
`endif
        end else begin
            wr_bank_q  <= wr_bank_d;
            tcol_q     <= tcol_d;
            full_q     <= full_d;
            rd_bank_q  <= rd_bank_d;
            row_q      <= row_d;
            col_q      <= col_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
`ifdef OTS_ROW_LAST_EN
            row_last_q <= row_last_d;
`endif
        end
    end

    assign o_data       = data_q;
    assign o_data_valid = valid_q;
`ifdef OTS_ROW_LAST_EN
    assign o_row_last   = row_last_q;
`endif

endmodule

// File: tb/tb_out_tile_serializer.sv
// Randomized bench for out_tile_serializer (OW=4, m=2) against a queue-based pixel-order model.
// Row-last checks are active when OTS_ROW_LAST_EN is defined.
module tb_out_tile_serializer;

    localparam int OW  = 4;
    localparam int M   = 2;
    localparam int TPB = OW / M;
    localparam int PPB = OW * M;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [M*M*8-1:0] tile = '0;
    logic             tv = 1'b0;
    logic             dr = 1'b0;
    logic             ready;
    logic [7:0]       data;
    logic             dv;
`ifdef OTS_ROW_LAST_EN
    logic             row_last;
`endif

    always #5 clk = ~clk;

    out_tile_serializer #(.OW(OW), .m(M)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_tile       (tile),
        .i_tile_valid (tv),
        .o_tile_ready (ready),
        .o_data       (data),
        .o_data_valid (dv),
        .i_data_ready (dr)
`ifdef OTS_ROW_LAST_EN
        ,
        .o_row_last   (row_last)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: pixels of a completed bank sit in stage_q for one edge, then become deliverable.
    logic [7:0] exp_q[$];
    logic [7:0] stage_q[$];
    logic [7:0] grp [M][OW];
    int         tiles_in_grp = 0;
    int         nfull = 0;
    int         out_cnt = 0;
    int         xfers = 0;

    task automatic cycle(input bit rst, input bit tvi, input logic [31:0] ti, input bit dri);
        bit acc, xfer;
        @(negedge clk);
        chk("tile_ready", 32'(ready), 32'(nfull < 2));
        chk("data_valid", 32'(dv), 32'(exp_q.size() > 0));
        if (dv === 1'b1 && exp_q.size() > 0) begin
            chk("data", 32'(data), 32'(exp_q[0]));
`ifdef OTS_ROW_LAST_EN
            chk("row_last", 32'(row_last), 32'((out_cnt % OW) == OW - 1));
`endif
        end
        rst_n = !rst;
        tv    = tvi;
        tile  = ti;
        dr    = dri;
        acc   = !rst && tvi && (nfull < 2);
        xfer  = !rst && dri && (exp_q.size() > 0);
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            stage_q.delete();
            tiles_in_grp = 0;
            nfull = 0;
            out_cnt = 0;
        end else begin
            foreach (stage_q[i]) exp_q.push_back(stage_q[i]);
            stage_q.delete();
            if (xfer) begin
                $display("pixel %0d: %02h", out_cnt, exp_q[0]);
                void'(exp_q.pop_front());
                out_cnt++;
                xfers++;
                if (out_cnt % PPB == 0) nfull--;
            end
            if (acc) begin
                for (int r = 0; r < M; r++)
                    for (int c = 0; c < M; c++)
                        grp[r][tiles_in_grp*M + c] = ti[((M-1-r)*M + (M-1-c))*8 +: 8];
                tiles_in_grp++;
                if (tiles_in_grp == TPB) begin
                    for (int r = 0; r < M; r++)
                        for (int c = 0; c < OW; c++)
                            stage_q.push_back(grp[r][c]);
                    tiles_in_grp = 0;
                    nfull++;
                end
            end
        end
    endtask

    initial begin
        logic [31:0] t0, t1, t2, t3;
        int start;
        t0 = 32'h10112021;
        t1 = 32'h12132223;
        t2 = 32'h30314041;
        t3 = 32'h32334243;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tile_ready", 32'(ready), 32'd1);
        chk("rst_data_valid", 32'(dv), 32'd0);
        chk("rst_data", 32'(data), 32'h00);

        // Two tiles, then drain with ready high
        cycle(0, 1, t0, 1);
        cycle(0, 1, t1, 1);
        repeat (12) cycle(0, 0, 32'h0, 1);

        // Four tiles with downstream stalled; extra tiles while full are ignored
        cycle(0, 1, t0, 0);
        cycle(0, 1, t1, 0);
        cycle(0, 1, t2, 0);
        cycle(0, 1, t3, 0);
        repeat (3) cycle(0, 1, $urandom, 0);
        #1;
        chk("hold_data", 32'(data), 32'h10);
        chk("hold_valid", 32'(dv), 32'd1);
        chk("full_ready", 32'(ready), 32'd0);
        repeat (20) cycle(0, 0, 32'h0, 1);

        // Reset after three pixels of a bank have transferred
        cycle(0, 1, t2, 1);
        cycle(0, 1, t3, 1);
        start = xfers;
        for (int i = 0; i < 20 && xfers - start < 3; i++) cycle(0, 0, 32'h0, 1);
        chk("pre_rst_xfers", 32'(xfers - start), 32'd3);
        cycle(1, 0, 32'h0, 1);
        #1;
        chk("midrst_valid", 32'(dv), 32'd0);
        chk("midrst_data", 32'(data), 32'h00);
        chk("midrst_ready", 32'(ready), 32'd1);
        cycle(0, 1, t0, 1);
        cycle(0, 1, t1, 1);
        repeat (12) cycle(0, 0, 32'h0, 1);

        // Random traffic
        for (int i = 0; i < 400; i++)
            cycle(0, bit'($urandom_range(0, 1)), $urandom, bit'($urandom_range(0, 1)));

        // Continuous tiles with ready toggling 1,0
        for (int i = 0; i < 120; i++) cycle(0, 1, $urandom, bit'(i % 2 == 0));

        // Drain everything left
        repeat (40) cycle(0, 0, 32'h0, 1);
        chk("drained", 32'(exp_q.size() + stage_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
